// File: rtl/rsa_uart_loader_pkg.sv
// Shared constants for the RSA UART loader: FSM encodings, error codes and frame defaults.
package rsa_uart_loader_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_M = 3'd1;
    localparam logic [2:0] ST_LOAD_E = 3'd2;
    localparam logic [2:0] ST_LOAD_K = 3'd3;
    localparam logic [2:0] ST_START  = 3'd4;
    localparam logic [2:0] ST_WAIT   = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_TIMEOUT  = 2'd1,
        ERR_BREAK    = 2'd2,
        ERR_ZERO_MOD = 2'd3
    } err_e;

    localparam logic [7:0] SYNC_BYTE_DEF   = 8'hA5;
    localparam int         TIMEOUT_CYC_DEF = 1000000;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rsa_uart_loader_operand_shift_reg.sv
// Byte-wide shift-in operand register; first byte shifted in ends up as the MSB.
module operand_shift_reg
    import rsa_uart_loader_pkg::*;
#(
    parameter int BYTE_W = 8,
    parameter int NBYTES = 4,
    localparam int W     = BYTE_W * NBYTES
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    input  logic              clr_i,
    input  logic              shift_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [W-1:0]      q_o,
    output logic              zero_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;
    logic [W-1:0] shifted;

    assign shifted = (q_q << BYTE_W) | W'(byte_i);
    // Zero test on the value the register would hold after taking byte_i.
    assign zero_o  = (shifted == '0);
    assign q_o     = q_q;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (shift_i) begin
            q_d = shifted;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/rsa_uart_loader.sv
// Frames UART bytes into message/exponent/modulus operands, starts the RSA core and holds its result.
//  state    | meaning
//  IDLE     | waiting for the sync header
//  LOAD_M   | shifting in message bytes
//  LOAD_E   | shifting in exponent bytes
//  LOAD_K   | shifting in modulus bytes
//  START    | one-cycle core start pulse
//  WAIT     | waiting for core_done
//  DONE     | result held, waiting for the next header
module rsa_uart_loader
    import rsa_uart_loader_pkg::*;
#(
    parameter int                      PAYLOAD_BITS  = 8,
    parameter int                      OPERAND_BYTES = 4,
    parameter logic [PAYLOAD_BITS-1:0] SYNC_BYTE     = SYNC_BYTE_DEF,
    parameter int                      TIMEOUT_CYC   = TIMEOUT_CYC_DEF,
    localparam int                     W             = OPERAND_BYTES * PAYLOAD_BITS
) (
    input  logic                    clk_i,
    input  logic                    resetn_i,
    input  logic                    rx_valid_i,
    input  logic [PAYLOAD_BITS-1:0] rx_data_i,
    input  logic                    rx_break_i,
    output logic                    core_start_o,
    output logic [W-1:0]            core_msg_o,
    output logic [W-1:0]            core_exp_o,
    output logic [W-1:0]            core_mod_o,
    input  logic                    core_done_i,
    input  logic [W-1:0]            core_result_i,
    output logic [W-1:0]            result_o,
    output logic                    result_valid_o,
    output logic                    busy_o,
    output logic [1:0]              err_o,
    output logic                    overrun_o
);

    localparam int               CNT_W     = cnt_width(OPERAND_BYTES);
    localparam int               TO_W      = cnt_width(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(OPERAND_BYTES - 1);
    localparam logic [TO_W-1:0]  GAP_LOAD  = TO_W'(TIMEOUT_CYC - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [TO_W-1:0]  gap_q, gap_d;
    err_e             err_q, err_d;
    logic             overrun_q, overrun_d;
    logic [W-1:0]     result_q, result_d;
    logic             result_valid_q, result_valid_d;

    logic [2:0]       shift_en;
    logic             clr_ops;
    logic [W-1:0]     op_q [3];
    logic             op_next_zero [3];
    logic             in_load;

    for (genvar i = 0; i < 3; i++) begin : g_op
        operand_shift_reg #(
            .BYTE_W (PAYLOAD_BITS),
            .NBYTES (OPERAND_BYTES)
        ) u_op (
            .clk_i    (clk_i),
            .resetn_i (resetn_i),
            .clr_i    (clr_ops),
            .shift_i  (shift_en[i]),
            .byte_i   (rx_data_i),
            .q_o      (op_q[i]),
            .zero_o   (op_next_zero[i])
        );
    end

    assign in_load = (state_q == ST_LOAD_M) || (state_q == ST_LOAD_E) || (state_q == ST_LOAD_K);

    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        gap_d          = gap_q;
        err_d          = err_q;
        overrun_d      = overrun_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        shift_en       = 3'b000;
        clr_ops        = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (rx_valid_i && (rx_data_i == SYNC_BYTE)) begin
                    state_d        = ST_LOAD_M;
                    byte_cnt_d     = '0;
                    gap_d          = GAP_LOAD;
                    err_d          = ERR_NONE;
                    overrun_d      = 1'b0;
                    result_valid_d = 1'b0;
                end
            end
            ST_LOAD_M, ST_LOAD_E, ST_LOAD_K: begin
                if (rx_break_i) begin
                    err_d   = ERR_BREAK;
                    clr_ops = 1'b1;
                    state_d = ST_IDLE;
                end else if (rx_valid_i) begin
                    gap_d    = GAP_LOAD;
                    shift_en = {state_q == ST_LOAD_K, state_q == ST_LOAD_E, state_q == ST_LOAD_M};
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d = '0;
                        if (state_q == ST_LOAD_M) begin
                            state_d = ST_LOAD_E;
                        end else if (state_q == ST_LOAD_E) begin
                            state_d = ST_LOAD_K;
                        end else if (op_next_zero[2]) begin
                            err_d   = ERR_ZERO_MOD;
                            clr_ops = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_START;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    end
                end else if (gap_q == '0) begin
                    err_d   = ERR_TIMEOUT;
                    clr_ops = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - TO_W'(1);
                end
            end
            ST_START: begin
                if (rx_break_i) begin
                    err_d   = ERR_BREAK;
                    state_d = ST_IDLE;
                end else begin
                    if (rx_valid_i) begin
                        overrun_d = 1'b1;
                    end
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Break wins over a coincident core_done: the run is abandoned.
                if (rx_break_i) begin
                    err_d   = ERR_BREAK;
                    state_d = ST_IDLE;
                end else begin
                    if (rx_valid_i) begin
                        overrun_d = 1'b1;
                    end
                    if (core_done_i) begin
                        result_d       = core_result_i;
                        result_valid_d = 1'b1;
                        state_d        = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q        <= ST_IDLE;
            byte_cnt_q     <= '0;
            gap_q          <= '0;
            err_q          <= ERR_NONE;
            overrun_q      <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            gap_q          <= gap_d;
            err_q          <= err_d;
            overrun_q      <= overrun_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign core_start_o   = (state_q == ST_START) && !rx_break_i;
    assign core_msg_o     = op_q[0];
    assign core_exp_o     = op_q[1];
    assign core_mod_o     = op_q[2];
    assign result_o       = result_q;
    assign result_valid_o = result_valid_q;
    assign busy_o         = in_load || (state_q == ST_START) || (state_q == ST_WAIT);
    assign err_o          = err_q;
    assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_rsa_uart_loader.sv
// Directed bench for rsa_uart_loader with a frame-level reference model checked every cycle.
module tb_rsa_uart_loader;

    localparam int TO = 40;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_break = 1'b0;
    logic        core_start;
    logic [31:0] core_msg, core_exp, core_mod;
    logic        core_done = 1'b0;
    logic [31:0] core_result = 32'h0;
    logic [31:0] result;
    logic        result_valid, busy, overrun;
    logic [1:0]  err;

    int n_checks = 0;
    int n_pass   = 0;
    int n_starts = 0;

    rsa_uart_loader #(.TIMEOUT_CYC(TO)) dut (
        .clk_i          (clk),
        .resetn_i       (resetn),
        .rx_valid_i     (rx_valid),
        .rx_data_i      (rx_data),
        .rx_break_i     (rx_break),
        .core_start_o   (core_start),
        .core_msg_o     (core_msg),
        .core_exp_o     (core_exp),
        .core_mod_o     (core_mod),
        .core_done_i    (core_done),
        .core_result_i  (core_result),
        .result_o       (result),
        .result_valid_o (result_valid),
        .busy_o         (busy),
        .err_o          (err),
        .overrun_o      (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp_v);
    endtask

    // Reference model: phase 0 quiet, 1..3 collecting operand (phase-1), 4 start, 5 waiting for core.
    int          m_phase = 0;
    int          m_cnt = 0;
    int          m_gap = 0;
    logic [31:0] m_op [3] = '{32'h0, 32'h0, 32'h0};
    logic [1:0]  m_err = 2'd0;
    logic        m_ovr = 1'b0;
    logic        m_rv = 1'b0;
    logic [31:0] m_res = 32'h0;

    always @(posedge clk) begin
        if (!resetn) begin
            m_phase = 0; m_cnt = 0; m_gap = 0; m_err = 0; m_ovr = 0; m_rv = 0; m_res = 0;
            for (int i = 0; i < 3; i++) m_op[i] = 32'h0;
        end else if (m_phase == 0) begin
            if (rx_valid && rx_data == 8'hA5) begin
                m_phase = 1; m_cnt = 0; m_gap = 0; m_err = 0; m_ovr = 0; m_rv = 0;
            end
        end else if (m_phase <= 3) begin
            if (rx_break) begin
                m_err = 2; m_phase = 0;
                for (int i = 0; i < 3; i++) m_op[i] = 32'h0;
            end else if (rx_valid) begin
                m_op[m_phase-1] = m_op[m_phase-1] * 256 + {24'h0, rx_data};
                m_cnt++;
                m_gap = 0;
                if (m_cnt == 4) begin
                    m_cnt = 0;
                    if (m_phase < 3) m_phase++;
                    else if (m_op[2] == 0) begin
                        m_err = 3; m_phase = 0;
                        for (int i = 0; i < 3; i++) m_op[i] = 32'h0;
                    end else m_phase = 4;
                end
            end else if (m_gap == TO - 1) begin
                m_err = 1; m_phase = 0;
                for (int i = 0; i < 3; i++) m_op[i] = 32'h0;
            end else m_gap++;
        end else begin
            if (rx_break) begin
                m_err = 2; m_phase = 0;
            end else begin
                if (rx_valid) m_ovr = 1;
                if (m_phase == 4) m_phase = 5;
                else if (core_done) begin
                    m_res = core_result; m_rv = 1; m_phase = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("core_start", {31'h0, core_start}, {31'h0, (m_phase == 4) && !rx_break});
        chk("core_msg", core_msg, m_op[0]);
        chk("core_exp", core_exp, m_op[1]);
        chk("core_mod", core_mod, m_op[2]);
        chk("result", result, m_res);
        chk("result_valid", {31'h0, result_valid}, {31'h0, m_rv});
        chk("busy", {31'h0, busy}, {31'h0, m_phase != 0});
        chk("err", {30'h0, err}, {30'h0, m_err});
        chk("overrun", {31'h0, overrun}, {31'h0, m_ovr});
        if (core_start === 1'b1) n_starts++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [31:0] t;
        t = w;
        for (int i = 3; i >= 0; i--) send(t[i*8 +: 8]);
    endtask

    initial begin
        int s0;
        tick();
        tick();
        @(negedge clk);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_result", result, 32'h0);
        resetn = 1'b1;
        tick();

        // Normal frame with an extra byte arriving while the core runs.
        send(8'hA5);
        send_word(32'h0000_0041);
        send_word(32'h0001_0001);
        send_word(32'h0000_0CA1);
        @(negedge clk);
        chk("start_latency", {31'h0, core_start}, 32'h1);
        tick();
        @(negedge clk);
        chk("start_one_cycle", {31'h0, core_start}, 32'h0);
        chk("op_msg", core_msg, 32'h41);
        chk("op_exp", core_exp, 32'h10001);
        chk("op_mod", core_mod, 32'hCA1);
        send(8'h77);
        @(negedge clk);
        chk("overrun_set", {31'h0, overrun}, 32'h1);
        chk("overrun_msg_kept", core_msg, 32'h41);
        core_done = 1'b1; core_result = 32'h0000_0B2F;
        tick();
        core_done = 1'b0;
        @(negedge clk);
        chk("result_value", result, 32'hB2F);
        chk("result_valid", {31'h0, result_valid}, 32'h1);
        chk("start_count_a", n_starts, 1);

        // New header clears flags but keeps result; reset lands mid-exponent.
        send(8'hA5);
        @(negedge clk);
        chk("overrun_cleared", {31'h0, overrun}, 32'h0);
        chk("result_kept", result, 32'hB2F);
        send_word(32'h1234_5678);
        send(8'h9A);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        @(negedge clk);
        chk("midload_reset_busy", {31'h0, busy}, 32'h0);
        chk("midload_reset_msg", core_msg, 32'h0);
        chk("midload_reset_result", result, 32'h0);
        core_done = 1'b1; core_result = 32'hFFFF_FFFF;
        tick();
        core_done = 1'b0;
        @(negedge clk);
        chk("stale_done_ignored", {31'h0, result_valid}, 32'h0);

        // Inter-byte timeout after five bytes.
        s0 = n_starts;
        send(8'hA5);
        send_word(32'h0102_0304);
        send(8'h05);
        repeat (TO - 1) tick();
        @(negedge clk);
        chk("timeout_not_yet", {31'h0, busy}, 32'h1);
        tick();
        @(negedge clk);
        chk("timeout_err", {30'h0, err}, 32'h1);
        chk("timeout_idle", {31'h0, busy}, 32'h0);
        chk("timeout_no_start", n_starts, s0);
        send(8'hA5);
        @(negedge clk);
        chk("header_clears_err", {30'h0, err}, 32'h0);
        rx_break = 1'b1;
        tick();
        rx_break = 1'b0;
        @(negedge clk);
        chk("break_in_load", {30'h0, err}, 32'h2);

        // Sync value as data, then zero modulus.
        send(8'hA5);
        send_word(32'hA5A5_A5A5);
        @(negedge clk);
        chk("sync_as_data", core_msg, 32'hA5A5A5A5);
        chk("sync_as_data_busy", {31'h0, busy}, 32'h1);
        send_word(32'h0000_0003);
        send_word(32'h0000_0000);
        @(negedge clk);
        chk("zero_mod_err", {30'h0, err}, 32'h3);
        chk("zero_mod_no_start", n_starts, s0);

        // Break coincident with core_done in WAIT.
        send(8'hA5);
        send_word(32'h0000_0002);
        send_word(32'h0000_0005);
        send_word(32'h0000_000D);
        tick();
        rx_break = 1'b1; core_done = 1'b1; core_result = 32'h0000_0007;
        tick();
        rx_break = 1'b0; core_done = 1'b0;
        @(negedge clk);
        chk("break_wait_err", {30'h0, err}, 32'h2);
        chk("break_wait_rv", {31'h0, result_valid}, 32'h0);
        chk("break_wait_starts", n_starts, s0 + 1);

        tick();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
